fpu_issue_collect: RTL and testbench

FPU_ISSUE_COLLECT -- requirements
Module: fpu_issue_collect

---
 rtl/fpu_issue_collect.sv | 93 +++++++++
 tb/tb_fpu_issue_collect.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_collect.sv
// Issues operands into a fixed-latency pipelined float unit and collects its results
// into an in-order response FIFO, using credits so the FIFO can never overflow.
module fpu_issue_collect #(
  parameter int LATENCY = 5,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [TAG_W-1:0] req_tag,
  output logic             unit_en,
  output logic [31:0]      unit_a,
  input  logic [31:0]      unit_q,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_q,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + $clog2(LATENCY + 1) + 1;

  logic [LATENCY-1:0] sr_vld;
  logic [TAG_W-1:0]   sr_tag [LATENCY];
  logic [TAG_W+31:0]  mem [DEPTH];
  logic [TAG_W+31:0]  head;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      fifo_count;
  logic [SW-1:0]      inflight, credit_used;
  logic               accept, fifo_wr, fifo_rd, fifo_full;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) inflight = inflight + SW'(sr_vld[i]);
  end

  // Credits cover both in-flight operands and buffered results, from registered state only.
  assign credit_used = inflight + SW'(fifo_count);
  assign req_ready   = !areset && (credit_used < SW'(DEPTH));
  assign accept      = req_valid && req_ready;
  assign unit_en     = accept || (inflight != '0);
  assign unit_a      = accept ? req_a : 32'h0;

  assign fifo_wr    = sr_vld[LATENCY-1];
  assign resp_valid = (fifo_count != '0);
  assign fifo_rd    = resp_valid && resp_ready;
  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign head       = mem[rd_ptr];
  assign resp_q     = resp_valid ? head[31:0] : 32'h0;
  assign resp_tag   = resp_valid ? head[TAG_W+31:32] : '0;
  assign busy       = (inflight != '0) || (fifo_count != '0);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sr_vld <= '0;
      for (int i = 0; i < LATENCY; i++) sr_tag[i] <= '0;
    end else begin
      sr_vld[0] <= accept;
      sr_tag[0] <= req_tag;
      for (int i = 1; i < LATENCY; i++) begin
        sr_vld[i] <= sr_vld[i-1];
        sr_tag[i] <= sr_tag[i-1];
      end
    end
  end

  // Storage needs no reset: entries are only visible while fifo_count covers them.
  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {sr_tag[LATENCY-1], unit_q};
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(fifo_wr) - CW'(fifo_rd);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (areset)
    !(fifo_wr && fifo_full && !fifo_rd))
    else $error("result written to a full FIFO");

endmodule

// File: tb/tb_fpu_issue_collect.sv
// Directed bench for fpu_issue_collect with a behavioural sqrt-class unit model.
module tb_fpu_issue_collect;
  localparam int LAT = 5;
  localparam int TW  = 4;
  localparam int DEP = 8;

  logic          clk, areset;
  logic          req_valid, req_ready;
  logic [31:0]   req_a;
  logic [TW-1:0] req_tag;
  logic          unit_en;
  logic [31:0]   unit_a, unit_q;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_q;
  logic [TW-1:0] resp_tag;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  fpu_issue_collect #(.LATENCY(LAT), .TAG_W(TW), .DEPTH(DEP)) dut (
    .clk(clk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_tag(req_tag),
    .unit_en(unit_en), .unit_a(unit_a), .unit_q(unit_q),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_q(resp_q), .resp_tag(resp_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Known square roots; anything else gets a recognisable scramble so bubbles show as A5A50000.
  function automatic logic [31:0] fmodel(input logic [31:0] a);
    case (a)
      32'h41800000: return 32'h40800000;
      32'h40800000: return 32'h40000000;
      32'h41100000: return 32'h40400000;
      32'h3F800000: return 32'h3F800000;
      default:      return a ^ 32'hA5A50000;
    endcase
  endfunction

  // Result appears on unit_q LATENCY edges after the operand is sampled; en low flushes.
  logic [31:0] upipe [LAT];
  always_ff @(posedge clk) begin
    if (!unit_en) begin
      for (int i = 0; i < LAT; i++) upipe[i] <= 32'h0;
    end else begin
      upipe[0] <= fmodel(unit_a);
      for (int i = 1; i < LAT; i++) upipe[i] <= upipe[i-1];
    end
  end
  assign unit_q = upipe[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0]   a;
    logic [TW-1:0] tag;
    logic [31:0]   exp_q;
    logic [TW-1:0] exp_tag;
  } vec_t;
  vec_t vecs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, en_cnt, acc, cnt, n_en, n_rv, n_busy;
    logic [TW-1:0] got_tag [$];
    logic [31:0]   got_q [$];

    vecs[0] = '{32'h41800000, 4'd3,  32'h40800000, 4'd3};
    vecs[1] = '{32'h40800000, 4'd5,  32'h40000000, 4'd5};
    vecs[2] = '{32'h41100000, 4'd9,  32'h40400000, 4'd9};
    vecs[3] = '{32'h3F800000, 4'd0,  32'h3F800000, 4'd0};
    vecs[4] = '{32'h12345678, 4'd15, 32'hB7915678, 4'd15};

    areset = 1'b1; req_valid = 1'b1; req_a = 32'h41800000; req_tag = 4'd1; resp_ready = 1'b1;
    repeat (2) cyc();
    smp();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_unit_en", unit_en, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_q", resp_q, 0);
    chk("rst_resp_tag", resp_tag, 0);
    cyc();
    areset = 1'b0; req_valid = 1'b0;
    smp();
    chk("ready_after_release", req_ready, 1);

    // Single requests: latency, result, tag and unit_en window.
    for (int v = 0; v < 5; v++) begin
      cyc();
      req_valid = 1'b1; req_a = vecs[v].a; req_tag = vecs[v].tag;
      smp();
      chk("vec_ready", req_ready, 1);
      en_cnt = int'(unit_en);
      cyc();
      req_valid = 1'b0; req_a = 32'h0;
      smp();
      en_cnt += int'(unit_en);
      lat = 0;
      while (!resp_valid && lat < 20) begin
        cyc(); smp();
        lat++;
        en_cnt += int'(unit_en);
      end
      chk("vec_latency", lat, LAT);
      chk("vec_q", resp_q, vecs[v].exp_q);
      chk("vec_tag", resp_tag, vecs[v].exp_tag);
      chk("vec_en_cycles", en_cnt, LAT + 1);
      cyc(); smp();
      chk("vec_idle_after", busy, 0);
    end

    // Backpressure: credits stop acceptance at DEPTH, release after the first pop.
    cyc();
    resp_ready = 1'b0; acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_tag = TW'(i); req_a = 32'h40000000 | i;
      smp();
      if (req_ready) acc++;
      cyc();
    end
    req_valid = 1'b0;
    smp();
    chk("bp_accepted", acc, 8);
    chk("bp_ready_low", req_ready, 0);
    repeat (8) cyc();
    resp_ready = 1'b1;
    smp();
    chk("bp_ready_before_pop", req_ready, 0);
    for (int k = 0; k < 8; k++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_tag", resp_tag, k);
      cyc(); smp();
      if (k == 0) chk("bp_ready_after_pop", req_ready, 1);
    end
    chk("bp_drained", resp_valid, 0);

    // Bubbles between requests must not become FIFO entries.
    cyc();
    for (int c = 0; c < 25; c++) begin
      req_valid = (c == 0 || c == 2 || c == 7);
      req_tag   = (c == 0) ? 4'd1 : (c == 2) ? 4'd2 : 4'd3;
      req_a     = 32'h41800000;
      smp();
      if (resp_valid) begin
        got_tag.push_back(resp_tag);
        got_q.push_back(resp_q);
      end
      cyc();
    end
    req_valid = 1'b0;
    chk("bub_count", got_tag.size(), 3);
    for (int j = 0; j < got_tag.size() && j < 3; j++) begin
      chk("bub_tag", got_tag[j], j + 1);
      chk("bub_q", got_q[j], 32'h40800000);
    end

    // Pop of the only entry on the same edge as a capture.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_tag = 4'd4; req_a = 32'h40800000;
    smp(); cyc();
    req_tag = 4'd5; req_a = 32'h41100000;
    smp(); cyc();
    req_valid = 1'b0;
    smp();
    lat = 0;
    while (!resp_valid && lat < 20) begin
      cyc(); smp();
      lat++;
    end
    chk("sim_first_tag", resp_tag, 4);
    resp_ready = 1'b1;
    cyc(); smp();
    chk("sim_valid_held", resp_valid, 1);
    chk("sim_new_tag", resp_tag, 5);
    chk("sim_new_q", resp_q, 32'h40400000);
    cyc(); smp();
    chk("sim_single_entry", resp_valid, 0);

    // Reset while three operands are in flight.
    cyc();
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_tag = TW'(10 + i); req_a = 32'h41800000;
      smp(); cyc();
    end
    req_valid = 1'b0;
    cyc(); cyc();
    areset = 1'b1; req_valid = 1'b1;
    smp();
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_unit_en", unit_en, 0);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_resp_q", resp_q, 0);
    chk("mid_rst_resp_tag", resp_tag, 0);
    cyc(); cyc();
    areset = 1'b0; req_valid = 1'b0;
    smp();
    chk("mid_rst_ready_release", req_ready, 1);
    cnt = 0;
    repeat (20) begin
      cyc(); smp();
      if (resp_valid) cnt++;
    end
    chk("mid_rst_no_resp", cnt, 0);

    // Idle.
    n_en = 0; n_rv = 0; n_busy = 0;
    repeat (50) begin
      cyc(); smp();
      if (unit_en) n_en++;
      if (resp_valid) n_rv++;
      if (busy) n_busy++;
    end
    chk("idle_unit_en", n_en, 0);
    chk("idle_resp_valid", n_rv, 0);
    chk("idle_busy", n_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
